// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if
// Handshake and serial-line bundle for the UART transmit framer.
//
// Signals:
//   P_DATA     parallel byte offered by the upstream logic
//   Data_Valid request strobe (level; honoured only while the framer is idle)
//   PAR_EN     parity enable, captured with the byte
//   PAR_TYP    parity type (0 = even, 1 = odd), captured with the byte
//   TX_OUT     serial line, idles high
//   busy       high while a frame is in flight
//
// Modports:
//   master  upstream side (drives request, observes line/busy)
//   slave   framer side
// ---------------------------------------------------------------------------
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit. One serial bit per rising clk edge.
//
// Ports:
//   clk    TX bit clock
//   rst    asynchronous reset, active-low
//   tx_if  uart_tx_frame_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP in;
//          TX_OUT, busy out)
//
// Parameters:
//   DATA_WIDTH  data bits per frame, 5..9
//
// Build option:
//   UART_TX_PARITY_EN  when defined, builds the parity generator, the PARITY
//                      state and the captured PAR_EN/PAR_TYP. When undefined,
//                      PAR_EN/PAR_TYP are ignored and frames carry no parity.
//
// States:
//   state  | meaning
//   IDLE   | line high, waiting for Data_Valid
//   START  | start bit (0) on the line
//   DATA   | data bits on the line, LSB first
//   PARITY | parity bit on the line (parity builds only)
//   STOP   | stop bit (1) on the line, last busy cycle
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_frame_if.slave    tx_if
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic                  tx_q,    tx_d;
    logic                  busy_q,  busy_d;

`ifdef UART_TX_PARITY_EN
    logic par_en_q,  par_en_d;
    logic par_bit_q, par_bit_d;
`else
    // Ports stay for pin compatibility but carry no meaning in this build.
    logic unused_par;
    assign unused_par = tx_if.PAR_EN ^ tx_if.PAR_TYP;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_if.Data_Valid) begin
                    shift_d   = tx_if.P_DATA;
                    cnt_d     = '0;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = tx_if.PAR_EN;
                    // Odd parity is the even parity bit inverted.
                    par_bit_d = (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
`endif
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            START: begin
                // Bit 0 goes out next; the register shifts so bit 0 is
                // always the next bit to drive.
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = CW'(1);
                state_d = DATA;
            end

            DATA: begin
                if (cnt_q < CNT_LAST) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
`ifdef UART_TX_PARITY_EN
                end else if (par_en_q) begin
                    tx_d    = par_bit_q;
                    state_d = PARITY;
`endif
                end else begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d    = 1'b1;
                state_d = STOP;
            end
`endif

            STOP: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame (DATA_WIDTH = 8). Frames are captured as
// bit vectors {stop, [parity], data[7:0], start} with bit 0 = first bit on
// the line. Expectations follow UART_TX_PARITY_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_WIDTH(8)) tx_if ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (tx_if.slave)
    );

    // Drives a request at a negedge, releases it one cycle later; returns at
    // the negedge where the start bit is on the line.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
        tx_if.P_DATA     = d;
        tx_if.PAR_EN     = pe;
        tx_if.PAR_TYP    = pt;
        tx_if.Data_Valid = 1'b1;
        @(negedge clk);
        tx_if.Data_Valid = 1'b0;
    endtask

    // Records TX_OUT once per cycle while busy is high (bounded); returns at
    // the first negedge with busy low.
    task automatic capture(output logic [15:0] seq, output int n);
        n   = 0;
        seq = '0;
        while (tx_if.busy === 1'b1 && n < 16) begin
            seq[n] = tx_if.TX_OUT;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [15:0] seq;
        int n;
        #1 rst = 1'b0;
        #1;
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: tx=%b busy=%b expected tx=1 busy=0", tx_if.TX_OUT, tx_if.busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: tx=%b busy=%b expected tx=1 busy=0", tx_if.TX_OUT, tx_if.busy);
        end

        // Mid-frame reset after four data bits of an all-zero byte.
        start_frame(8'h00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if (tx_if.TX_OUT !== 1'b0 || tx_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_midframe_pre: tx=%b busy=%b expected tx=0 busy=1", tx_if.TX_OUT, tx_if.busy);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_midframe_async: tx=%b busy=%b expected tx=1 busy=0", tx_if.TX_OUT, tx_if.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_residual cycle %0d: tx=%b busy=%b expected tx=1 busy=0", i, tx_if.TX_OUT, tx_if.busy);
            end
        end
        start_frame(8'hA5, 1'b0, 1'b0);
        capture(seq, n);
        total++;
        if (seq !== 16'h034A || n !== 10) begin
            bad++;
            $display("FAIL reset_first_frame: seq=%h len=%0d expected seq=034a len=10", seq, n);
        end
    endtask

    task automatic test_no_parity();
        logic [15:0] seq;
        int n;
        logic [7:0]  d   [3] = '{8'hA5, 8'hFF, 8'h00};
        logic [15:0] exp [3] = '{16'h034A, 16'h03FE, 16'h0200};
        for (int i = 0; i < 3; i++) begin
            start_frame(d[i], 1'b0, 1'b1);
            capture(seq, n);
            total++;
            if (seq !== exp[i] || n !== 10) begin
                bad++;
                $display("FAIL no_parity %h: seq=%h len=%0d expected seq=%h len=10", d[i], seq, n, exp[i]);
            end
        end
    endtask

    task automatic test_even_parity();
        logic [15:0] seq;
        int n;
`ifdef UART_TX_PARITY_EN
        logic [15:0] exp = 16'h0602;
        int          len = 11;
`else
        logic [15:0] exp = 16'h0202;
        int          len = 10;
`endif
        start_frame(8'h01, 1'b1, 1'b0);
        capture(seq, n);
        total++;
        if (seq !== exp || n !== len) begin
            bad++;
            $display("FAIL even_parity 01: seq=%h len=%0d expected seq=%h len=%0d", seq, n, exp, len);
        end
    endtask

    task automatic test_odd_parity();
        logic [15:0] seq;
        int n;
        logic [7:0]  d  [3] = '{8'hA5, 8'hA5, 8'h01};
        logic        pt [3] = '{1'b1, 1'b0, 1'b1};
`ifdef UART_TX_PARITY_EN
        logic [15:0] exp [3] = '{16'h074A, 16'h054A, 16'h0402};
        int          len = 11;
`else
        logic [15:0] exp [3] = '{16'h034A, 16'h034A, 16'h0202};
        int          len = 10;
`endif
        for (int i = 0; i < 3; i++) begin
            start_frame(d[i], 1'b1, pt[i]);
            capture(seq, n);
            total++;
            if (seq !== exp[i] || n !== len) begin
                bad++;
                $display("FAIL parity_type %h typ=%b: seq=%h len=%0d expected seq=%h len=%0d", d[i], pt[i], seq, n, exp[i], len);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [15:0] seq;
        int n;
        start_frame(8'hA5, 1'b0, 1'b0);
        fork
            capture(seq, n);
            begin
                repeat (3) @(negedge clk);
                tx_if.P_DATA     = 8'h3C;
                tx_if.Data_Valid = 1'b1;
                @(negedge clk);
                tx_if.Data_Valid = 1'b0;
            end
        join
        total++;
        if (seq !== 16'h034A || n !== 10) begin
            bad++;
            $display("FAIL busy_ignore frame: seq=%h len=%0d expected seq=034a len=10", seq, n);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tx_if.busy !== 1'b0 || tx_if.TX_OUT !== 1'b1) begin
                bad++;
                $display("FAIL busy_ignore no_queue cycle %0d: busy=%b tx=%b expected busy=0 tx=1", i, tx_if.busy, tx_if.TX_OUT);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq;
        int n;
        start_frame(8'h5A, 1'b0, 1'b0);
        fork
            capture(seq, n);
            begin
                repeat (2) @(negedge clk);
                tx_if.P_DATA     = 8'hC3;
                tx_if.Data_Valid = 1'b1;
            end
        join
        total++;
        if (seq !== 16'h02B4 || n !== 10) begin
            bad++;
            $display("FAIL b2b first frame: seq=%h len=%0d expected seq=02b4 len=10", seq, n);
        end
        total++;
        if (tx_if.TX_OUT !== 1'b1) begin
            bad++;
            $display("FAIL b2b idle_gap: tx=%b expected 1", tx_if.TX_OUT);
        end
        @(negedge clk);
        tx_if.Data_Valid = 1'b0;
        total++;
        if (tx_if.busy !== 1'b1 || tx_if.TX_OUT !== 1'b0) begin
            bad++;
            $display("FAIL b2b restart: busy=%b tx=%b expected busy=1 tx=0", tx_if.busy, tx_if.TX_OUT);
        end
        capture(seq, n);
        total++;
        if (seq !== 16'h0386 || n !== 10) begin
            bad++;
            $display("FAIL b2b second frame: seq=%h len=%0d expected seq=0386 len=10", seq, n);
        end
    endtask

    task automatic test_config_latch();
        logic [15:0] seq;
        int n;
`ifdef UART_TX_PARITY_EN
        logic [15:0] exp = 16'h074A;
        int          len = 11;
`else
        logic [15:0] exp = 16'h034A;
        int          len = 10;
`endif
        start_frame(8'hA5, 1'b1, 1'b1);
        fork
            capture(seq, n);
            begin
                repeat (3) @(negedge clk);
                tx_if.PAR_EN  = 1'b0;
                tx_if.PAR_TYP = 1'b0;
                tx_if.P_DATA  = 8'h3C;
            end
        join
        total++;
        if (seq !== exp || n !== len) begin
            bad++;
            $display("FAIL config_latch: seq=%h len=%0d expected seq=%h len=%0d", seq, n, exp, len);
        end
    endtask

    initial begin
        tx_if.P_DATA     = '0;
        tx_if.Data_Valid = 1'b0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        test_reset();
        test_no_parity();
        test_even_parity();
        test_odd_parity();
        test_busy_ignore();
        test_back_to_back();
        test_config_latch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
